// File: rtl/instr_mem_loader.sv
// Boot loader: assembles little-endian bytes into 32-bit words and writes them to the instruction RAM, holding the CPU in reset.
// Latency: 5 cycles/word minimum (4 byte accepts + 1 write); byte_ready drops during write, idle and finish.
module instr_mem_loader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t          state;
    logic [ADDR_W:0] count_q;
    logic [1:0]      byte_idx;
    logic [23:0]     word_q;
    logic [ADDR_W:0] written;

    // Words written once the current WRITE completes; compared against the latched count.
    assign written = {1'b0, mem_addr} + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count_q    <= '0;
            byte_idx   <= '0;
            word_q     <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0 && word_count <= DEPTH_W) begin
                            count_q    <= word_count;
                            mem_addr   <= '0;
                            byte_idx   <= '0;
                            checksum   <= '0;
                            cpu_hold   <= 1'b1;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state      <= RECV;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_valid && byte_ready) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_q[7:0]   <= byte_data;
                            2'd1: word_q[15:8]  <= byte_data;
                            2'd2: word_q[23:16] <= byte_data;
                            default: begin
                                mem_wdata  <= {byte_data, word_q};
                                mem_we     <= 1'b1;
                                byte_ready <= 1'b0;
                                state      <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    checksum <= checksum ^ mem_wdata;
                    if (written == count_q) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        mem_addr   <= mem_addr + ADDR_W'(1);
                        byte_idx   <= '0;
                        byte_ready <= 1'b1;
                        state      <= RECV;
                    end
                end
                default: begin
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed/randomized bench for instr_mem_loader against a byte-list reference model.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int tests = 0;
    int fails = 0;
    int overlap = 0;
    logic [38:0] got_q[$];
    logic [7:0]  bytes[$];

    instr_mem_loader #(.ADDR_W(7), .DEPTH(128)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) got_q.push_back({mem_addr, mem_wdata});
        if (mem_we && byte_ready) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, ".mem_we"},     64'(mem_we),     64'd0);
        chk({tag, ".mem_addr"},   64'(mem_addr),   64'd0);
        chk({tag, ".mem_wdata"},  64'(mem_wdata),  64'd0);
        chk({tag, ".cpu_hold"},   64'(cpu_hold),   64'd1);
        chk({tag, ".busy"},       64'(busy),       64'd0);
        chk({tag, ".done"},       64'(done),       64'd0);
        chk({tag, ".error"},      64'(error),      64'd0);
        chk({tag, ".checksum"},   64'(checksum),   64'd0);
    endtask

    task automatic rand_bytes(input int n);
        bytes.delete();
        for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
    endtask

    // mode: 0 = valid held high, 1 = valid alternating, 2 = random valid
    task automatic run_load(input string tag, input int n, input int mode, input bit extra_start);
        int idx = 0;
        int cyc = 0;
        int base;
        int errs = 0;
        bit saw_done = 0;
        logic [31:0] w;
        logic [31:0] exp_sum = '0;
        base = got_q.size();
        start = 1'b1;
        word_count = 8'(n);
        tick();
        start = 1'b0;
        chk({tag, ".busy_after_start"}, 64'(busy), 64'd1);
        chk({tag, ".ready_after_start"}, 64'(byte_ready), 64'd1);
        while (!saw_done && cyc < 20 * n + 20) begin
            if (done) begin
                saw_done = 1;
            end else begin
                case (mode)
                    0: byte_valid = 1'b1;
                    1: byte_valid = (cyc % 2) == 0;
                    default: byte_valid = 1'($urandom_range(0, 1));
                endcase
                if (idx >= 4 * n) byte_valid = 1'b0;
                byte_data = (idx < 4 * n) ? bytes[idx] : 8'h00;
                if (extra_start && cyc == 3) begin
                    start = 1'b1;
                    word_count = 8'd1;
                end else begin
                    start = 1'b0;
                end
                if (error) errs++;
                if (byte_valid && byte_ready) idx++;
                tick();
                cyc++;
            end
        end
        byte_valid = 1'b0;
        start = 1'b0;
        chk({tag, ".done_seen"}, 64'(saw_done), 64'd1);
        if (mode == 0) chk({tag, ".cycles"}, 64'(cyc), 64'(5 * n));
        if (extra_start) chk({tag, ".no_error"}, 64'(errs), 64'd0);
        chk({tag, ".hold_in_finish"}, 64'(cpu_hold), 64'd1);
        chk({tag, ".last_addr"}, 64'(mem_addr), 64'(n - 1));
        tick();
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".hold_released"}, 64'(cpu_hold), 64'd0);
        chk({tag, ".busy_cleared"}, 64'(busy), 64'd0);
        chk({tag, ".ready_cleared"}, 64'(byte_ready), 64'd0);
        chk({tag, ".write_count"}, 64'(got_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            exp_sum ^= w;
            if (base + i < got_q.size())
                chk($sformatf("%s.write%0d", tag, i), 64'(got_q[base+i]), 64'({7'(i), w}));
        end
        chk({tag, ".checksum"}, 64'(checksum), 64'(exp_sum));
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        start = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        tick();
        chk_reset("reset");
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("idle_ready%0d", i), 64'(byte_ready), 64'd0);
        end
        chk_reset("idle");
        byte_valid = 1'b0;

        bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("b2b", 2, 0, 0);
        chk("b2b.const_sum", 64'(checksum), 64'h0010_0080);
        run_load("toggle", 2, 1, 0);
        chk("toggle.overlap", 64'(overlap), 64'd0);

        start = 1'b1;
        word_count = 8'd0;
        tick();
        start = 1'b0;
        chk("cnt0.error", 64'(error), 64'd1);
        chk("cnt0.busy", 64'(busy), 64'd0);
        tick();
        chk("cnt0.error_pulse", 64'(error), 64'd0);
        start = 1'b1;
        word_count = 8'd129;
        tick();
        start = 1'b0;
        chk("cnt129.error", 64'(error), 64'd1);
        chk("cnt129.busy", 64'(busy), 64'd0);
        chk("cnt129.hold", 64'(cpu_hold), 64'd0);

        rand_bytes(128);
        run_load("full", 128, 0, 0);
        rand_bytes(3);
        run_load("ign_start", 3, 2, 1);
        chk("ign_start.overlap", 64'(overlap), 64'd0);

        rand_bytes(3);
        start = 1'b1;
        word_count = 8'd3;
        tick();
        start = 1'b0;
        byte_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && acc < 6; i++) begin
            byte_data = bytes[acc];
            if (byte_ready) acc++;
            tick();
        end
        byte_valid = 1'b0;
        chk("midrst.accepted", 64'(acc), 64'd6);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        tick();
        rst = 1'b0;
        tick();
        rand_bytes(1);
        run_load("after_rst", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
